// File: rtl/core_list_scanner.sv
// core_list_scanner
// AXI4-Lite read initiator that walks the core list ROM one 64-byte entry at a
// time. It looks for the entry whose CoreTypeNr and CoreInstNr equal the search
// keys, and returns that entry's address range and interrupt mask.
// A scan ends on one of four conditions:
//   - a match,
//   - a CoreTypeNr of 0, which terminates the list,
//   - the entry limit,
//   - a non-OKAY read response.
// Optional feature macro: CORE_LIST_SCANNER_TIMEOUT_EN. When it is defined, a
// per-transaction watchdog aborts a read that stalls for TimeoutCycles_Gen clocks.
module core_list_scanner #(
    parameter logic [15:0] BaseAddr_Gen      = 16'h0000,
    parameter int unsigned MaxEntries_Gen    = 64,
    parameter int unsigned TimeoutCycles_Gen = 1024
) (
    input  logic        SysClk_ClkIn,
    input  logic        SysRstN_RstIn,
    input  logic        Start_EvtIn,
    input  logic [31:0] SearchTypeNr_DatIn,
    input  logic [31:0] SearchInstNr_DatIn,
    output logic        Busy_DatOut,
    output logic        Done_EvtOut,
    output logic        Found_DatOut,
    output logic        Error_DatOut,
    output logic [9:0]  EntryIndex_DatOut,
    output logic [31:0] AddrLow_DatOut,
    output logic [31:0] AddrHigh_DatOut,
    output logic [31:0] IrqMask_DatOut,
    output logic        AxiReadAddrValid_ValOut,
    input  logic        AxiReadAddrReady_RdyIn,
    output logic [15:0] AxiReadAddrAddress_AdrOut,
    output logic [2:0]  AxiReadAddrProt_DatOut,
    input  logic        AxiReadDataValid_ValIn,
    output logic        AxiReadDataReady_RdyOut,
    input  logic [1:0]  AxiReadDataResponse_DatIn,
    input  logic [31:0] AxiReadDataData_DatIn
);

    if (MaxEntries_Gen < 1 || MaxEntries_Gen > 1024) begin : g_bad_max_entries
        $error("core_list_scanner: MaxEntries_Gen must be in 1..1024");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_EVAL,
        ST_DONE
    } state_e;

    // The word of the current entry that is being fetched.
    typedef enum logic [2:0] {
        FLD_TYPE,
        FLD_INST,
        FLD_LOW,
        FLD_HIGH,
        FLD_MASK
    } field_e;

    // Eleven bits, so that the limit 1024 can be represented.
    localparam logic [10:0] MaxIdx   = 11'(MaxEntries_Gen);
    localparam logic [1:0]  RespOkay = 2'b00;

    function automatic logic [15:0] field_offset(input field_e f);
        case (f)
            FLD_TYPE: field_offset = 16'h0000;
            FLD_INST: field_offset = 16'h0004;
            FLD_LOW:  field_offset = 16'h000C;
            FLD_HIGH: field_offset = 16'h0010;
            FLD_MASK: field_offset = 16'h0014;
            default:  field_offset = 16'h0000;
        endcase
    endfunction

    state_e      state_q, state_d;
    field_e      field_q, field_d;
    logic [31:0] type_key_q, type_key_d;
    logic [31:0] inst_key_q, inst_key_d;
    logic [31:0] word_q, word_d;
    logic [9:0]  idx_q, idx_d;
    logic        found_q, found_d;
    logic        error_q, error_d;
    logic [31:0] low_q, low_d;
    logic [31:0] high_q, high_d;
    logic [31:0] mask_q, mask_d;
    logic [15:0] araddr_q, araddr_d;
    // Goes high on the first clock after reset. It keeps RREADY low while the
    // block is still in reset, even though the Idle state otherwise drains R.
    logic        live_q;

    logic        ar_fire;
    logic        r_fire;
    logic        timeout;
    logic        advance;
    logic [10:0] idx_inc;
    logic [15:0] addr_next;

    assign ar_fire = AxiReadAddrValid_ValOut & AxiReadAddrReady_RdyIn;
    assign r_fire  = AxiReadDataValid_ValIn & AxiReadDataReady_RdyOut;

`ifdef CORE_LIST_SCANNER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TimeoutCycles_Gen + 1);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Watchdog count: restarts on entry to Addr or Data, and runs while the block stays there.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if ((state_d == ST_ADDR || state_d == ST_DATA) && state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if (state_q == ST_ADDR || state_q == ST_DATA) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
        if (!SysRstN_RstIn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout = (state_q == ST_ADDR || state_q == ST_DATA) &&
                     (tmo_cnt_q == TmoW'(TimeoutCycles_Gen - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TimeoutCycles_Gen;
    assign timeout = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
        // NOTE: every register here has a reset value, because each one drives
        // an output or a state decision that must read as 0 right after reset.
        if (!SysRstN_RstIn) begin
            state_q    <= ST_IDLE;
            field_q    <= FLD_TYPE;
            type_key_q <= '0;
            inst_key_q <= '0;
            word_q     <= '0;
            idx_q      <= '0;
            found_q    <= 1'b0;
            error_q    <= 1'b0;
            low_q      <= '0;
            high_q     <= '0;
            mask_q     <= '0;
            araddr_q   <= '0;
            live_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so that every register samples the
            // values from before the edge, whatever the statement order.
            state_q    <= state_d;
            field_q    <= field_d;
            type_key_q <= type_key_d;
            inst_key_q <= inst_key_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            found_q    <= found_d;
            error_q    <= error_d;
            low_q      <= low_d;
            high_q     <= high_d;
            mask_q     <= mask_d;
            araddr_q   <= araddr_d;
            live_q     <= 1'b1;
        end
    end

    // Next-state and datapath update: sequencing of the walk over the entry list.
    always_comb begin
        // NOTE: every variable takes its held value first, so that no path
        // through the case statement leaves a variable unassigned and infers a latch.
        state_d    = state_q;
        field_d    = field_q;
        type_key_d = type_key_q;
        inst_key_d = inst_key_q;
        word_d     = word_q;
        idx_d      = idx_q;
        found_d    = found_q;
        error_d    = error_q;
        low_d      = low_q;
        high_d     = high_q;
        mask_d     = mask_q;
        araddr_d   = araddr_q;
        advance    = 1'b0;
        idx_inc    = {1'b0, idx_q} + 11'd1;
        addr_next  = '0;

        case (state_q)
            ST_IDLE: begin
                if (Start_EvtIn) begin
                    type_key_d = SearchTypeNr_DatIn;
                    inst_key_d = SearchInstNr_DatIn;
                    found_d    = 1'b0;
                    error_d    = 1'b0;
                    low_d      = '0;
                    high_d     = '0;
                    mask_d     = '0;
                    idx_d      = '0;
                    field_d    = FLD_TYPE;
                    state_d    = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (ar_fire) begin
                    state_d = ST_DATA;
                end else if (timeout) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_DATA: begin
                if (r_fire) begin
                    if (AxiReadDataResponse_DatIn != RespOkay) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        word_d = AxiReadDataData_DatIn;
                        case (field_q)
                            FLD_LOW:  low_d  = AxiReadDataData_DatIn;
                            FLD_HIGH: high_d = AxiReadDataData_DatIn;
                            FLD_MASK: mask_d = AxiReadDataData_DatIn;
                            default:  ;
                        endcase
                        state_d = ST_EVAL;
                    end
                end else if (timeout) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_EVAL: begin
                case (field_q)
                    FLD_TYPE: begin
                        if (word_q == '0) begin
                            state_d = ST_DONE;
                        end else if (word_q == type_key_q) begin
                            field_d = FLD_INST;
                            state_d = ST_ADDR;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                    FLD_INST: begin
                        if (word_q == inst_key_q) begin
                            field_d = FLD_LOW;
                            state_d = ST_ADDR;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                    FLD_LOW: begin
                        field_d = FLD_HIGH;
                        state_d = ST_ADDR;
                    end
                    FLD_HIGH: begin
                        field_d = FLD_MASK;
                        state_d = ST_ADDR;
                    end
                    FLD_MASK: begin
                        found_d = 1'b1;
                        state_d = ST_DONE;
                    end
                    default: state_d = ST_DONE;
                endcase

                // When the limit is 1024, the reported index wraps to 0.
                if (advance) begin
                    idx_d = idx_inc[9:0];
                    if (idx_inc == MaxIdx) begin
                        state_d = ST_DONE;
                    end else begin
                        field_d = FLD_TYPE;
                        state_d = ST_ADDR;
                    end
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase

        // The address is loaded once on entry to Addr, so it stays stable for the whole handshake.
        addr_next = BaseAddr_Gen + {idx_d, 6'b000000} + field_offset(field_d);
        if (state_d == ST_ADDR && state_q != ST_ADDR) begin
            araddr_d = addr_next;
        end
    end

    // Output decode from the current state.
    always_comb begin
        AxiReadAddrValid_ValOut = 1'b0;
        AxiReadDataReady_RdyOut = 1'b0;
        Busy_DatOut             = 1'b0;
        Done_EvtOut             = 1'b0;
        case (state_q)
            ST_IDLE: AxiReadDataReady_RdyOut = live_q;
            ST_ADDR: begin
                AxiReadAddrValid_ValOut = 1'b1;
                Busy_DatOut             = 1'b1;
            end
            ST_DATA: begin
                AxiReadDataReady_RdyOut = 1'b1;
                Busy_DatOut             = 1'b1;
            end
            ST_EVAL: Busy_DatOut = 1'b1;
            ST_DONE: Done_EvtOut = 1'b1;
            default: ;
        endcase
    end

    assign Found_DatOut              = found_q;
    assign Error_DatOut              = error_q;
    assign EntryIndex_DatOut         = idx_q;
    assign AddrLow_DatOut            = low_q;
    assign AddrHigh_DatOut           = high_q;
    assign IrqMask_DatOut            = mask_q;
    assign AxiReadAddrAddress_AdrOut = araddr_q;
    assign AxiReadAddrProt_DatOut    = 3'b000;

endmodule

// File: tb/tb_core_list_scanner.sv
// Self-checking bench for core_list_scanner.
// The bench provides a randomised-latency AXI4-Lite slave that serves a
// word-addressed ROM image. A behavioural model walks the same image entry by
// entry and produces the expected outcome and the expected AR address sequence.
// Directed scans compare the results against hand-computed literals. Random
// scans rely on the model.
module tb_core_list_scanner;

    localparam logic [15:0] BASE  = 16'h0000;
    localparam int          MAX_E = 8;
    localparam int          TMO   = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] stype = '0;
    logic [31:0] sinst = '0;
    logic        busy, done, found, error;
    logic [9:0]  idx;
    logic [31:0] low, high, mask;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [15:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [1:0]  rresp = 2'b00;
    logic [31:0] rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] rom_w [0:255];
    logic [15:0] exp_ar [$];
    logic [15:0] ar_log [$];
    int          ar_count    = 0;
    int          err_at      = -1;
    int          hold_r_from = 32'h4000_0000;
    bit          hold_ar     = 1'b0;

    bit          m_found, m_err;
    logic [9:0]  m_idx;
    logic [31:0] m_low, m_high, m_mask;

    always #5 clk = ~clk;

    core_list_scanner #(
        .BaseAddr_Gen      (BASE),
        .MaxEntries_Gen    (MAX_E),
        .TimeoutCycles_Gen (TMO)
    ) dut (
        .SysClk_ClkIn              (clk),
        .SysRstN_RstIn             (rst_n),
        .Start_EvtIn               (start),
        .SearchTypeNr_DatIn        (stype),
        .SearchInstNr_DatIn        (sinst),
        .Busy_DatOut               (busy),
        .Done_EvtOut               (done),
        .Found_DatOut              (found),
        .Error_DatOut              (error),
        .EntryIndex_DatOut         (idx),
        .AddrLow_DatOut            (low),
        .AddrHigh_DatOut           (high),
        .IrqMask_DatOut            (mask),
        .AxiReadAddrValid_ValOut   (arvalid),
        .AxiReadAddrReady_RdyIn    (arready),
        .AxiReadAddrAddress_AdrOut (araddr),
        .AxiReadAddrProt_DatOut    (arprot),
        .AxiReadDataValid_ValIn    (rvalid),
        .AxiReadDataReady_RdyOut   (rready),
        .AxiReadDataResponse_DatIn (rresp),
        .AxiReadDataData_DatIn     (rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // AXI slave. All inputs change on the falling edge. A handshake is decided
    // from the values that hold at the next rising edge.
    initial begin : slave
        bit          pend      = 1'b0;
        bit          pend_err  = 1'b0;
        bit          r_fire_pv = 1'b0;
        int          pend_num  = 0;
        int          lat       = 0;
        logic [15:0] pend_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0; r_fire_pv = 1'b0;
                arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
            end else begin
                if (r_fire_pv) begin
                    rvalid = 1'b0;
                    pend   = 1'b0;
                end
                arready = hold_ar ? 1'b0 : ($urandom_range(0, 2) != 0);
                if (pend && !rvalid) begin
                    if (lat > 0) lat--;
                    else if (pend_num < hold_r_from) begin
                        rvalid = 1'b1;
                        rresp  = pend_err ? 2'b10 : 2'b00;
                        rdata  = pend_err ? $urandom : rom_w[pend_addr[9:2]];
                    end
                end
                r_fire_pv = rvalid && rready;
                if (arvalid && arready) begin
                    ar_log.push_back(araddr);
                    if (exp_ar.size() > 0) check("ar_addr", 32'(araddr), 32'(exp_ar.pop_front()));
                    pend      = 1'b1;
                    pend_addr = araddr;
                    pend_num  = ar_count;
                    pend_err  = (ar_count == err_at);
                    lat       = $urandom_range(0, 3);
                    ar_count++;
                end
            end
        end
    end

    task automatic clear_rom();
        for (int k = 0; k < 256; k++) rom_w[k] = '0;
    endtask

    task automatic set_entry(input int e, input logic [31:0] t, input logic [31:0] i,
                             input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] mk);
        rom_w[8'(e * 16 + 0)] = t;
        rom_w[8'(e * 16 + 1)] = i;
        rom_w[8'(e * 16 + 3)] = lo;
        rom_w[8'(e * 16 + 4)] = hi;
        rom_w[8'(e * 16 + 5)] = mk;
    endtask

    // Reference model, one read: logs the expected address and returns whether the response is OKAY.
    task automatic mread(input int a, inout int rd, input int err_rel,
                         output logic [31:0] w, output bit ok);
        exp_ar.push_back(16'(BASE + a));
        ok = (rd != err_rel);
        if (!ok) m_err = 1'b1;
        w  = rom_w[8'(a >> 2)];
        rd++;
    endtask

    // Reference model, whole scan: a walk of the entry list.
    task automatic model_scan(input logic [31:0] tk, input logic [31:0] ik, input int err_rel);
        int          rd = 0;
        logic [31:0] w;
        bit          ok;
        exp_ar.delete();
        m_found = 1'b0; m_err = 1'b0; m_idx = '0;
        m_low = '0; m_high = '0; m_mask = '0;
        for (int e = 0; e < MAX_E; e++) begin
            m_idx = 10'(e);
            mread(e * 64 + 0, rd, err_rel, w, ok);
            if (!ok || w == 0) return;
            if (w != tk) continue;
            mread(e * 64 + 4, rd, err_rel, w, ok);
            if (!ok) return;
            if (w != ik) continue;
            mread(e * 64 + 12, rd, err_rel, w, ok);
            if (!ok) return;
            m_low = w;
            mread(e * 64 + 16, rd, err_rel, w, ok);
            if (!ok) return;
            m_high = w;
            mread(e * 64 + 20, rd, err_rel, w, ok);
            if (!ok) return;
            m_mask  = w;
            m_found = 1'b1;
            return;
        end
        m_idx = 10'(MAX_E);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    32'(busy),    32'h0);
        check({tag, "_done"},    32'(done),    32'h0);
        check({tag, "_found"},   32'(found),   32'h0);
        check({tag, "_error"},   32'(error),   32'h0);
        check({tag, "_idx"},     32'(idx),     32'h0);
        check({tag, "_low"},     low,          32'h0);
        check({tag, "_high"},    high,         32'h0);
        check({tag, "_mask"},    mask,         32'h0);
        check({tag, "_arvalid"}, 32'(arvalid), 32'h0);
        check({tag, "_araddr"},  32'(araddr),  32'h0);
        check({tag, "_arprot"},  32'(arprot),  32'h0);
        check({tag, "_rready"},  32'(rready),  32'h0);
    endtask

    // A full scan. The outputs are compared against the model on every cycle
    // of the scan, at the Done pulse, and after it.
    task automatic run_scan(input logic [31:0] tk, input logic [31:0] ik,
                            input int err_rel, input bit poke);
        int base, exp_reads;
        bit seen_done = 1'b0;
        model_scan(tk, ik, err_rel);
        exp_reads = exp_ar.size();
        base      = ar_count;
        err_at    = (err_rel < 0) ? -1 : base + err_rel;
        ar_log.delete();
        @(negedge clk);
        stype = tk; sinst = ik; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'h1);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            start = 1'b0;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            check("scan_busy",   32'(busy),   32'h1);
            check("scan_found",  32'(found),  32'h0);
            check("scan_error",  32'(error),  32'h0);
            check("scan_arprot", 32'(arprot), 32'h0);
            if (poke && cyc == 3) begin
                start = 1'b1;
                stype = $urandom;
                sinst = $urandom;
            end
            @(negedge clk);
        end
        check("done_seen", 32'(seen_done), 32'h1);
        check("done_busy", 32'(busy),      32'h0);
        check("found",     32'(found),     32'(m_found));
        check("error",     32'(error),     32'(m_err));
        check("entry_idx", 32'(idx),       32'(m_idx));
        check("addr_low",  low,            m_low);
        check("addr_high", high,           m_high);
        check("irq_mask",  mask,           m_mask);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("post_done",  32'(done),  32'h0);
        check("post_busy",  32'(busy),  32'h0);
        check("hold_found", 32'(found), 32'(m_found));
        @(negedge clk);
        check("idle_busy",   32'(busy),   32'h0);
        check("idle_rready", 32'(rready), 32'h1);
        check("read_count",  32'(ar_count - base), 32'(exp_reads));
        err_at = -1;
    endtask

    task automatic load_test_rom();
        clear_rom();
        set_entry(0, 3, 1, 32'h1111_0000, 32'h1111_FFFF, 32'h1);
        set_entry(1, 5, 1, 32'h2222_0000, 32'h2222_FFFF, 32'h2);
        set_entry(2, 5, 2, 32'h0101_0000, 32'h0101_FFFF, 32'h4);
        set_entry(3, 0, 0, 32'h0,         32'h0,         32'h0);
    endtask

    initial begin : main
        logic [15:0] lit_seq [8];
        int          guard;
        int          cnt;
        bit          seen;
        lit_seq = '{16'h00, 16'h40, 16'h44, 16'h80, 16'h84, 16'h8C, 16'h90, 16'h94};
        clear_rom();

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_rready_after_reset", 32'(rready), 32'h1);

        // Directed: a match in entry 2.
        load_test_rom();
        run_scan(5, 2, -1, 1'b0);
        check("d1_found",     32'(found),         32'h1);
        check("d1_idx",       32'(idx),           32'h2);
        check("d1_low",       low,                32'h0101_0000);
        check("d1_high",      high,               32'h0101_FFFF);
        check("d1_mask",      mask,               32'h4);
        check("d1_error",     32'(error),         32'h0);
        check("d1_ar_count",  32'(ar_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < ar_log.size()) check("d1_ar_seq", 32'(ar_log[i]), 32'(lit_seq[i]));
        end

        // Directed: the zero terminator ends the scan.
        run_scan(7, 0, -1, 1'b0);
        check("d2_found",    32'(found),         32'h0);
        check("d2_idx",      32'(idx),           32'h3);
        check("d2_ar_count", 32'(ar_log.size()), 32'd4);
        if (ar_log.size() > 0) check("d2_last_ar", 32'(ar_log[ar_log.size() - 1]), 32'hC0);

        // Directed: SLVERR on the second read.
        run_scan(5, 2, 1, 1'b0);
        check("d4_error",    32'(error),         32'h1);
        check("d4_found",    32'(found),         32'h0);
        check("d4_idx",      32'(idx),           32'h1);
        check("d4_ar_count", 32'(ar_log.size()), 32'd2);

        // Directed: the entry limit is reached with no terminator in the list.
        clear_rom();
        for (int e = 0; e < MAX_E; e++) set_entry(e, 32'(e + 1), 1, 0, 0, 0);
        run_scan(9, 0, -1, 1'b0);
        check("d3_found",    32'(found),         32'h0);
        check("d3_idx",      32'(idx),           32'(MAX_E));
        check("d3_ar_count", 32'(ar_log.size()), 32'(MAX_E));

        // Extra Start pulses while Busy, and at Done.
        load_test_rom();
        run_scan(5, 2, -1, 1'b1);
        check("poke_found", 32'(found), 32'h1);
        check("poke_idx",   32'(idx),   32'h2);

        // Random scans against the model.
        for (int n = 0; n < 40; n++) begin
            int err_rel;
            clear_rom();
            for (int e = 0; e < MAX_E; e++) begin
                set_entry(e, ($urandom_range(0, 9) == 0) ? 32'h0 : 32'($urandom_range(1, 4)),
                          32'($urandom_range(0, 2)), $urandom, $urandom, $urandom);
            end
            err_rel = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_scan(32'($urandom_range(1, 5)), 32'($urandom_range(0, 2)), err_rel,
                     bit'($urandom_range(0, 1)));
        end

        // Reset asserted while the second read waits in the Data state.
        load_test_rom();
        model_scan(5, 2, -1);
        hold_r_from = ar_count + 1;
        guard = 0;
        @(negedge clk);
        stype = 5; sinst = 2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(ar_count >= hold_r_from + 1 && rready && busy) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("rst_reached_data", 32'(guard < 500), 32'h1);
        check("rst_pre_araddr",   32'(araddr),      32'h40);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        exp_ar.delete();
        hold_r_from = 32'h4000_0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_idle_busy",   32'(busy),   32'h0);
        check("rst_idle_rready", 32'(rready), 32'h1);

        // An AR channel that is never ready.
        model_scan(5, 2, -1);
        exp_ar.delete();
        hold_ar = 1'b1;
        @(negedge clk);
        stype = 5; sinst = 2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef CORE_LIST_SCANNER_TIMEOUT_EN
        cnt  = 0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (arvalid) cnt++;
            @(negedge clk);
        end
        check("tmo_done_seen",     32'(seen),    32'h1);
        check("tmo_arvalid_count", 32'(cnt),     32'(TMO));
        check("tmo_error",         32'(error),   32'h1);
        check("tmo_found",         32'(found),   32'h0);
        check("tmo_arvalid_drop",  32'(arvalid), 32'h0);
        hold_ar = 1'b0;
        @(negedge clk);
`else
        cnt = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (!busy || done) cnt++;
            @(negedge clk);
        end
        check("hang_busy_drops", 32'(cnt),     32'h0);
        check("hang_arvalid",    32'(arvalid), 32'h1);
        rst_n = 1'b0;
        #1;
        check_all_zero("hang_rst");
        hold_ar = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
